alu_ctrl: RTL and testbench
===========================

ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  single system clock, rising-edge.
REQ-002 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have port: instr_valid  input  1  instruction offered.
REQ-004 SHALL have port: instr_ready  output  1  controller can accept an instruction.
REQ-005 SHALL have port: instr  input  8  bits [7:5]=sel, [4:3]=rd, [2:1]=rs, [0]=use_imm.
REQ-006 SHALL have port: imm  input  8  immediate operand, sampled with instr.
REQ-007 SHALL have port: alu_op1 / alu_op2  output  8 each  registered operands to ALU.
REQ-008 SHALL have port: alu_sel  output  3  registered ALU select.
REQ-009 SHALL have port: alu_out  input  8  combinational ALU result.
REQ-010 SHALL have port: alu_co  input  1  ALU carry/shift-out.
REQ-011 SHALL have port: done  output  1  one-cycle pulse on writeback.
REQ-012 SHALL have port: carry  output  1  carry flag.
REQ-013 SHALL have port: dbg_addr  input  2  register-file read address.
REQ-014 SHALL have port: dbg_data  output  8  combinational R[dbg_addr].

Function
REQ-015 SHALL hold a 4x8 register file R0..R3 and FSM states IDLE, READ, EXEC.
REQ-016 SHALL drive instr_ready=1 only in IDLE; accept on rising edge with instr_valid & instr_ready, latching instr and imm, IDLE->READ.
REQ-017 At READ->EXEC edge SHALL load alu_sel=sel, alu_op2=use_imm?imm:R[rs], and alu_op1=R[rd], except sel=101 (MOV), where alu_op1=use_imm?imm:R[rs].
REQ-018 At EXEC->IDLE edge SHALL write alu_out into R[rd] and assert done for exactly the following cycle.
REQ-019 Latency: accept at edge E0 -> writeback and done rising at edge E2; next accept no earlier than E3.
REQ-020 SHALL update carry from alu_co only for sel 000, 001 and 011; other sel values leave carry unchanged.
REQ-021 A register read in READ SHALL see any value written at an earlier edge; no bypass is required.
REQ-022 alu_op1, alu_op2 and alu_sel SHALL hold their values outside the READ->EXEC load.
REQ-023 instr_valid in READ or EXEC SHALL be ignored and SHALL NOT alter latched state.
REQ-024 Unrecognised encodings do not exist: all 8 sel codes SHALL execute with writeback.

Reset
REQ-025 rst_n low SHALL immediately force IDLE, R0..R3=0, carry=0, done=0, alu_op1=alu_op2=0, alu_sel=000.
REQ-026 Reset during READ or EXEC SHALL abort the instruction with no writeback and no done.
REQ-027 After rst_n deasserts, instr_ready SHALL be 1 in the first cycle.

Configuration
REQ-028 With ALU_CTRL_ZFLAG_EN defined SHALL add output zero (1 bit), updated on every writeback to (alu_out==0) and reset to 0.
REQ-029 Without ALU_CTRL_ZFLAG_EN SHALL have no zero port and no zero-flag logic.

Verification
REQ-030 Reset: pulse rst_n low mid-run -> dbg_data=0x00 for all dbg_addr, carry=0, done=0, instr_ready=1, alu_sel=000.
REQ-031 MOV R1,#0xF0 (instr=0xA9, imm=0xF0), then ADD R1,#0x20 (instr=0x09, imm=0x20) -> R1=0x10, carry=1, done high one cycle after each E2.
REQ-032 Continuing from REQ-031, XNOR R1,#0x10 (instr=0x49, imm=0x10) -> R1=0xFF, carry stays 1.
REQ-033 instr_valid held high with MOV R2,#0x07 then ADD R2,R2 -> accepts at E0 and E3; R2=0x0E, carry=0; instr_ready low in READ and EXEC.
REQ-034 Abort: start ADD R0,#0x05; assert rst_n during EXEC -> R0 stays 0x00, done never asserts.
REQ-035 With ALU_CTRL_ZFLAG_EN defined, ADD R3,#0x00 on R3=0 -> zero=1; MOV R3,#0x01 -> zero=0.

Source files
------------

// File: rtl/alu_ctrl.sv
// alu_ctrl: three-state (IDLE/READ/EXEC) controller with a 4x8 register file driving an external combinational ALU.
// Latency: accept at E0, operands load at E1, writeback and done at E2; the next accept is possible at E3.
// Backpressure: instr_ready is high only in IDLE; instr_valid seen in READ/EXEC is ignored. Optional ALU_CTRL_ZFLAG_EN adds a zero flag.
module alu_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [7:0] instr,
    input  logic [7:0] imm,
    output logic [7:0] alu_op1,
    output logic [7:0] alu_op2,
    output logic [2:0] alu_sel,
    input  logic [7:0] alu_out,
    input  logic       alu_co,
    output logic       done,
    output logic       carry,
`ifdef ALU_CTRL_ZFLAG_EN
    output logic       zero,
`endif
    input  logic [1:0] dbg_addr,
    output logic [7:0] dbg_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2
    } state_t;

    localparam logic [2:0] SEL_MOV = 3'b101;

    state_t          state;
    logic [3:0][7:0] rf;

    // Instruction fields captured at accept; stable until the next accept.
    logic [2:0] lat_sel;
    logic [1:0] lat_rd;
    logic [1:0] lat_rs;
    logic       lat_use_imm;
    logic [7:0] lat_imm;

    logic [7:0] src_opnd;
    logic       carry_upd;

    // Second operand source: immediate or register, read from the file as it stands in READ.
    always_comb begin
        src_opnd = lat_use_imm ? lat_imm : rf[lat_rs];
    end

    // Only ADD, SUB and SHL-class selects (000, 001, 011) produce a meaningful carry-out.
    always_comb begin
        carry_upd = (alu_sel == 3'b000) || (alu_sel == 3'b001) || (alu_sel == 3'b011);
    end

    assign dbg_data = rf[dbg_addr];

    // Controller FSM: instruction latch, operand load, writeback and flag updates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            instr_ready <= 1'b1;
            rf          <= '0;
            lat_sel     <= 3'b000;
            lat_rd      <= 2'b00;
            lat_rs      <= 2'b00;
            lat_use_imm <= 1'b0;
            lat_imm     <= 8'h00;
            alu_op1     <= 8'h00;
            alu_op2     <= 8'h00;
            alu_sel     <= 3'b000;
            done        <= 1'b0;
            carry       <= 1'b0;
`ifdef ALU_CTRL_ZFLAG_EN
            zero        <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (instr_valid && instr_ready) begin
                        lat_sel     <= instr[7:5];
                        lat_rd      <= instr[4:3];
                        lat_rs      <= instr[2:1];
                        lat_use_imm <= instr[0];
                        lat_imm     <= imm;
                        instr_ready <= 1'b0;
                        state       <= READ;
                    end
                end
                READ: begin
                    alu_sel <= lat_sel;
                    alu_op2 <= src_opnd;
                    // MOV passes the source through op1 so the ALU can forward it unchanged.
                    alu_op1 <= (lat_sel == SEL_MOV) ? src_opnd : rf[lat_rd];
                    state   <= EXEC;
                end
                EXEC: begin
                    rf[lat_rd] <= alu_out;
                    done       <= 1'b1;
                    if (carry_upd) begin
                        carry <= alu_co;
                    end
`ifdef ALU_CTRL_ZFLAG_EN
                    zero <= (alu_out == 8'h00);
`endif
                    instr_ready <= 1'b1;
                    state       <= IDLE;
                end
                default: begin
                    instr_ready <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_ctrl.sv
// Bench for alu_ctrl: directed scenarios plus randomized instructions checked against an architectural model.
// The ALU itself lives here as a combinational function of the DUT's registered operands.
// Define ALU_CTRL_ZFLAG_EN for both files to exercise the zero flag.
module tb_alu_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] instr;
    logic [7:0] imm;
    logic [7:0] alu_op1;
    logic [7:0] alu_op2;
    logic [2:0] alu_sel;
    logic [7:0] alu_out;
    logic       alu_co;
    logic       done;
    logic       carry;
    logic [1:0] dbg_addr;
    logic [7:0] dbg_data;
`ifdef ALU_CTRL_ZFLAG_EN
    logic       zero;
`endif

    int checks = 0;
    int errors = 0;

    // Architectural model: register values and flags as a programmer sees them.
    logic [7:0] mr [4];
    logic       mc;
    logic       mz;

    always #5 clk = ~clk;

    alu_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .imm         (imm),
        .alu_op1     (alu_op1),
        .alu_op2     (alu_op2),
        .alu_sel     (alu_sel),
        .alu_out     (alu_out),
        .alu_co      (alu_co),
        .done        (done),
        .carry       (carry),
`ifdef ALU_CTRL_ZFLAG_EN
        .zero        (zero),
`endif
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    // ALU behaviour: {carry_out, result}.
    function automatic logic [8:0] alu_fn(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
        case (s)
            3'd0:    return {1'b0, a} + {1'b0, b};
            3'd1:    return {1'b0, a} - {1'b0, b};
            3'd2:    return {1'b0, ~(a ^ b)};
            3'd3:    return {a, 1'b0};
            3'd4:    return {1'b0, a & b};
            3'd5:    return {1'b0, a};
            3'd6:    return {1'b0, a | b};
            default: return {1'b0, a ^ b};
        endcase
    endfunction

    always_comb begin
        {alu_co, alu_out} = alu_fn(alu_sel, alu_op1, alu_op2);
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) mr[i] = 8'h00;
        mc = 1'b0;
        mz = 1'b0;
    endtask

    task automatic chk_regs(input string tag);
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i);
            #1;
            chk(tag, {8'h00, dbg_data}, {8'h00, mr[i]});
        end
    endtask

    // Pulse reset starting at a negedge; checks the asynchronous effect while held low.
    task automatic do_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        #1;
        model_clear();
        chk_regs("rst_rf");
        chk("rst_carry", {15'd0, carry}, 16'd0);
        chk("rst_done", {15'd0, done}, 16'd0);
        chk("rst_ready", {15'd0, instr_ready}, 16'd1);
        chk("rst_sel", {13'd0, alu_sel}, 16'd0);
        chk("rst_ops", {alu_op1, alu_op2}, 16'h0000);
`ifdef ALU_CTRL_ZFLAG_EN
        chk("rst_zero", {15'd0, zero}, 16'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {15'd0, instr_ready}, 16'd1);
    endtask

    // Idle cycles with no offer: done must be low and the controller ready.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_done", {15'd0, done}, 16'd0);
            chk("idle_ready", {15'd0, instr_ready}, 16'd1);
        end
    endtask

    // Called at a negedge; returns at the negedge after writeback with instr_valid low.
    task automatic run_instr(input logic [7:0] ins, input logic [7:0] im);
        logic [2:0] s;
        logic [1:0] rd;
        logic [1:0] rs;
        logic [7:0] src;
        logic [7:0] opa;
        logic [8:0] res;
        int         n;
        s   = ins[7:5];
        rd  = ins[4:3];
        rs  = ins[2:1];
        src = ins[0] ? im : mr[rs];
        opa = (s == 3'b101) ? src : mr[rd];
        res = alu_fn(s, opa, src);
        n = 0;
        while (!instr_ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_accept", {15'd0, instr_ready}, 16'd1);
        instr_valid = 1'b1;
        instr       = ins;
        imm         = im;
        @(negedge clk);
        // READ: offers must be refused; keep offering garbage to prove it is ignored.
        chk("ready_in_read", {15'd0, instr_ready}, 16'd0);
        chk("done_in_read", {15'd0, done}, 16'd0);
        instr = 8'($urandom);
        imm   = 8'($urandom);
        @(negedge clk);
        chk("ready_in_exec", {15'd0, instr_ready}, 16'd0);
        chk("exec_sel", {13'd0, alu_sel}, {13'd0, s});
        chk("exec_op1", {8'h00, alu_op1}, {8'h00, opa});
        chk("exec_op2", {8'h00, alu_op2}, {8'h00, src});
        instr = 8'($urandom);
        imm   = 8'($urandom);
        @(negedge clk);
        instr_valid = 1'b0;
        mr[rd] = res[7:0];
        if (s == 3'b000 || s == 3'b001 || s == 3'b011) mc = res[8];
        mz = (res[7:0] == 8'h00);
        chk("wb_done", {15'd0, done}, 16'd1);
        chk("wb_ready", {15'd0, instr_ready}, 16'd1);
        chk("wb_carry", {15'd0, carry}, {15'd0, mc});
        chk("hold_ops", {alu_op1, alu_op2}, {opa, src});
        chk("hold_sel", {13'd0, alu_sel}, {13'd0, s});
`ifdef ALU_CTRL_ZFLAG_EN
        chk("wb_zero", {15'd0, zero}, {15'd0, mz});
`endif
        dbg_addr = rd;
        #1;
        chk("wb_rd", {8'h00, dbg_data}, {8'h00, mr[rd]});
    endtask

    // Reset arriving while the instruction is in EXEC discards it completely.
    task automatic abort_test();
        logic [7:0] r0_before;
        r0_before = mr[0];
        instr_valid = 1'b1;
        instr       = 8'h01;
        imm         = 8'h05;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        chk("abort_in_exec_sel", {13'd0, alu_sel}, 16'd0);
        chk("abort_in_exec_op2", {8'h00, alu_op2}, {8'h00, 8'h05});
        rst_n = 1'b0;
        #1;
        model_clear();
        dbg_addr = 2'd0;
        #1;
        chk("abort_r0", {8'h00, dbg_data}, 16'h0000);
        chk("abort_done", {15'd0, done}, 16'd0);
        chk("abort_r0_before", {8'h00, r0_before}, {8'h00, r0_before & 8'h00});
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("abort_no_done", {15'd0, done}, 16'd0);
            chk("abort_r0_after", {8'h00, dbg_data}, 16'h0000);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = 8'h00;
        imm         = 8'h00;
        dbg_addr    = 2'd0;
        model_clear();
        #12;
        rst_n = 1'b1;
        do_reset();

        // MOV R1,#F0 ; ADD R1,#20 ; XNOR R1,#10
        run_instr(8'hA9, 8'hF0);
        idle(1);
        run_instr(8'h09, 8'h20);
        dbg_addr = 2'd1;
        #1;
        chk("add_r1", {8'h00, dbg_data}, 16'h0010);
        chk("add_carry", {15'd0, carry}, 16'd1);
        idle(2);
        run_instr(8'h49, 8'h10);
        dbg_addr = 2'd1;
        #1;
        chk("xnor_r1", {8'h00, dbg_data}, 16'h00FF);
        chk("xnor_carry", {15'd0, carry}, 16'd1);
        idle(1);

        do_reset();

        // Back-to-back: valid stays high from one call into the next.
        run_instr(8'hB1, 8'h07);
        run_instr(8'h14, 8'h00);
        dbg_addr = 2'd2;
        #1;
        chk("b2b_r2", {8'h00, dbg_data}, 16'h000E);
        chk("b2b_carry", {15'd0, carry}, 16'd0);
        idle(1);

        abort_test();

`ifdef ALU_CTRL_ZFLAG_EN
        run_instr(8'h19, 8'h00);
        chk("zero_set", {15'd0, zero}, 16'd1);
        run_instr(8'hB9, 8'h01);
        chk("zero_clr", {15'd0, zero}, 16'd0);
        idle(1);
`endif

        // Randomized instruction stream, occasionally back-to-back, with a mid-run reset.
        for (int k = 0; k < 80; k++) begin
            run_instr(8'($urandom), 8'($urandom));
            idle($urandom_range(0, 2));
            if (k == 40) do_reset();
        end
        chk_regs("final_rf");
        chk("final_carry", {15'd0, carry}, {15'd0, mc});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
